// File: rtl/ex_div.sv
// ex_div: iterative 32-bit restoring divider for MIPS DIV/DIVU.
// It stalls the front of the pipeline and presents {remainder, quotient} for one cycle.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        done,
    output logic [63:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [31:0] r, q, bm, am, bv;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;
    logic [32:0] r_sh;
    logic [33:0] trial;
    logic        unused_trial;
    assign am = (sign & a[31]) ? -a : a;
    assign bv = (sign & b[31]) ? -b : b;
    assign r_sh = {r, q[31]};
    // The remainder stays below |b| between steps, so 32 bits hold it once the trial succeeds.
    assign trial = {1'b0, r_sh} - {2'b0, bm};
    assign unused_trial = trial[32];
    assign done = state == DONE;
    assign stall = rst & ~flush & ((state == IDLE & start) | state == BUSY);
    assign result = {neg_r ? -r : r, neg_q ? -q : q};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            r     <= '0;
            q     <= '0;
            bm    <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    r     <= '0;
                    q     <= am;
                    bm    <= bv;
                    cnt   <= '0;
                    neg_q <= sign & (a[31] ^ b[31]);
                    neg_r <= sign & a[31];
                    state <= BUSY;
                end
                BUSY: begin
                    r     <= trial[33] ? r_sh[31:0] : trial[31:0];
                    q     <= {q[30:0], ~trial[33]};
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'd31) ? DONE : BUSY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
